inst_queue_ctrl: RTL and testbench
==================================

Name: inst_queue_ctrl

Overview:
Two-wide decoupling instruction queue and issue controller between the fetch stage and decode.
- Accepts up to two instructions per cycle on an IF_ID_Port bundle from fetch.
- Buffers them in program order.
- Issues up to two per cycle to decode as a second IF_ID_Port bundle.
- Honours the Local Flush/Stall controls and applies backpressure to fetch.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
PTR_W, $clog2(DEPTH), pointer width; count register is PTR_W+1 bits

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Flush  in  1  pipeline flush (branch mispredict / exception)
Stall  in  1  decode stall; no issue while high
In_Port  in  98  IF_ID_Port from fetch {Inst1, Inst1_en, Inst2, Inst2_en, PC}
In_Ready  out  1  queue can accept a full fetch pair this cycle
Out_Port  out  98  IF_ID_Port to decode
Count  out  PTR_W+1  current occupancy (debug/perf)

Behaviour:
- Entry format: {Inst[31:0], PC[31:0]}. Storage is a circular buffer with head and tail pointers; both wrap modulo DEPTH.
- Reset (Rst=1 at a rising edge): head=tail=0, Count=0, storage contents don't-care.
  - Outputs during and after reset: Out_Port.Inst1_en=0, Out_Port.Inst2_en=0, In_Ready=1.
  - Reset overrides every other input.
- In_Ready = (DEPTH - Count) >= 2, computed from registered Count only. Same-cycle pops are not credited.
- Push occurs when In_Ready=1 and the slot is enabled. Pushes with In_Ready=0 are dropped; fetch must hold its pair.
  - Inst1_en=1: Inst1 written with PC.
  - Inst2_en=1: Inst2 written with PC+4 (32-bit wrap) after Inst1.
  - Inst2_en=1 with Inst1_en=0: Inst2 pushed alone with PC+4.
  - Pushes 0..2 entries; tail advances by the number pushed.
- Issue view (combinational from registered state):
  - Out_Port.Inst1 and PC come from the head entry. Out_Port.Inst1_en = (Count>=1).
  - Out_Port.Inst2 comes from head+1 (wrapped). Out_Port.Inst2_en = (Count>=2) and (entry[head+1].PC == entry[head].PC + 4).
  - A non-sequential second entry (fetch redirect) is held for the next cycle.
- Pop:
  - Stall=0: head advances by Inst1_en + Inst2_en.
  - Stall=1: no pop; Out_Port is held stable.
  - Decode samples Out_Port only when Stall=0.
- Count_next = Count + pushed - popped, evaluated together. Simultaneous push and pop in one cycle is legal at any occupancy.
- Latency: an entry pushed at edge N is first visible on Out_Port in the cycle after edge N. There is no bypass.
- Flush=1 at an edge:
  - head=tail=0, Count=0; the same-cycle push and pop are discarded.
  - Next cycle: both Out enables are 0 and In_Ready=1.
  - Flush wins over Stall.
- Full: Count never exceeds DEPTH. A push with Count=DEPTH-1 is blocked, because In_Ready is already 0.
- Empty: Count=0 gives both Out enables 0. A pop with Stall=0 and nothing valid is a no-op.
- Assertions:
  - Count <= DEPTH.
  - No push while In_Ready=0 changes state.
  - Out_Port stable while Stall=1 and Flush=0.

Decomposition:
- Shared package System_Pkg additions:
  - typedef IQ_Entry {Inst, PC}.
  - localparam INST_BYTES=4 (the PC increment).
  - The controller reuses the existing Global, Local and IF_ID_Port types (Clk/Rst and Flush/Stall as separate ports here).
- Sub-module iq_storage: DEPTH-entry register array with two write ports (tail, tail+1) and two read ports (head, head+1). No reset on data.
- Pointer, count and issue logic stay in inst_queue_ctrl.

Test Plan:
1. Reset, then push {Inst1=0x2402_0001, Inst2=0x2403_0002, PC=0x0040_0000, both en}, Stall=0 -> next cycle Out PC=0x0040_0000, both en=1, Count=2; following cycle Count=0, both en=0.
2. Stall=1, push 4 pairs (DEPTH=8) -> In_Ready drops to 0 after Count=8 (after 4 pushes); 5th pair dropped, Count stays 8; release Stall -> 2 issued per cycle in order over 4 cycles.
3. Push PC=0x100 (Inst1 only), then PC=0x200 pair -> Out first issues 0x100 with Inst2_en=0, then 0x200/0x204 as a pair.
4. Count=5, Flush=1 with simultaneous push and Stall=0 -> next cycle Count=0, Out enables 0, In_Ready=1, no pop reported.
5. Run 3*DEPTH pushes/pops with random Stall -> pointer wrap verified; issue order matches push order; no loss or duplication (scoreboard).
6. Assert Rst mid-stream with Count=6 and Stall=1 -> next cycle Count=0, Out enables 0, In_Ready=1.

Source files
------------

// File: rtl/inst_queue_ctrl_pkg.sv
// Shared types for the fetch/decode instruction queue: queue entry, the
// IF/ID port bundle and the sequential-PC helper.
package inst_queue_ctrl_pkg;

    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    typedef struct packed {
        logic [31:0] inst1;
        logic        inst1_en;
        logic [31:0] inst2;
        logic        inst2_en;
        logic [31:0] pc;
    } if_id_port_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_queue_ctrl_chk.sv
// Property checker for the instruction queue controller: occupancy bound,
// no state growth while not ready, and issue data held during stall.
module inst_queue_ctrl_chk
    import inst_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    input logic         stall,
    input logic         in_ready,
    input logic [PTR_W:0] count,
    input logic [97:0]  out_port
);

    if_id_port_t out_s;
    assign out_s = if_id_port_t'(out_port);

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= (PTR_W+1)'(DEPTH));

    a_no_push_when_full: assert property (@(posedge clk)
        (!rst && !flush && !in_ready) |=> (count <= $past(count)));

    a_stall_hold_slot1: assert property (@(posedge clk)
        (!rst && !flush && stall && out_s.inst1_en) |=>
        (out_s.inst1_en && $stable(out_s.inst1) && $stable(out_s.pc)));

    a_stall_hold_slot2: assert property (@(posedge clk)
        (!rst && !flush && stall && out_s.inst2_en) |=>
        (out_s.inst2_en && $stable(out_s.inst2)));

endmodule

// File: rtl/iq_storage.sv
// Instruction queue data array: two write ports (tail, tail+1) and two
// combinational read ports (head, head+1). Data is not reset.
module iq_storage #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  logic [63:0]      wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  logic [63:0]      wdata1,
    input  logic [PTR_W-1:0] raddr0,
    output logic [63:0]      rdata0,
    input  logic [PTR_W-1:0] raddr1,
    output logic [63:0]      rdata1
);

    logic [63:0] mem_r [DEPTH];

    // Write ports; the controller only ever presents distinct addresses.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[waddr0] <= wdata0;
        end
        if (we1) begin
            mem_r[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/inst_queue_ctrl.sv
// Two-wide decoupling instruction queue between fetch and decode: buffers
// fetch pairs in program order and issues up to two sequential entries per cycle.
module inst_queue_ctrl
    import inst_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Flush,
    input  logic           Stall,
    input  logic [97:0]    In_Port,
    output logic           In_Ready,
    output logic [97:0]    Out_Port,
    output logic [PTR_W:0] Count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    if_id_port_t      in_s;
    if_id_port_t      out_s;
    iq_entry_t        wdata0_s;
    iq_entry_t        wdata1_s;
    iq_entry_t        head_s;
    iq_entry_t        next_s;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             push1_s;
    logic             push2_s;
    logic             we0_s;
    logic             we1_s;
    logic [1:0]       push_cnt_s;
    logic [1:0]       pop_cnt_s;
    logic             en1_s;
    logic             en2_s;

    assign in_s     = if_id_port_t'(In_Port);
    // Ready depends on registered occupancy only; same-cycle pops earn no credit.
    assign In_Ready = (DEPTH_C - count_r) >= TWO_C;

    // Write-port steering: a lone Inst2 takes the tail slot with PC+4.
    always_comb begin
        push1_s  = In_Ready & in_s.inst1_en & ~Flush & ~Rst;
        push2_s  = In_Ready & in_s.inst2_en & ~Flush & ~Rst;
        wdata0_s = '{inst: in_s.inst1, pc: in_s.pc};
        wdata1_s = '{inst: in_s.inst2, pc: next_pc(in_s.pc)};
        we0_s    = 1'b0;
        we1_s    = 1'b0;
        if (push1_s) begin
            we0_s = 1'b1;
            we1_s = push2_s;
        end else if (push2_s) begin
            we0_s    = 1'b1;
            wdata0_s = wdata1_s;
        end else begin
            we0_s = 1'b0;
        end
        push_cnt_s = {1'b0, push1_s} + {1'b0, push2_s};
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk    (Clk),
        .we0    (we0_s),
        .waddr0 (tail_r),
        .wdata0 (wdata0_s),
        .we1    (we1_s),
        .waddr1 (tail_r + PTR_W'(1)),
        .wdata1 (wdata1_s),
        .raddr0 (head_r),
        .rdata0 (head_s),
        .raddr1 (head_r + PTR_W'(1)),
        .rdata1 (next_s)
    );

    // Issue view: second slot only pairs with a sequential PC, otherwise it waits.
    always_comb begin
        en1_s     = count_r >= ONE_C;
        en2_s     = (count_r >= TWO_C) && (next_s.pc == next_pc(head_s.pc));
        pop_cnt_s = Stall ? 2'd0 : ({1'b0, en1_s} + {1'b0, en2_s});
        out_s     = '{inst1:    head_s.inst,
                      inst1_en: en1_s,
                      inst2:    next_s.inst,
                      inst2_en: en2_s,
                      pc:       head_s.pc};
    end

    assign Out_Port = out_s;
    assign Count    = count_r;

    // Pointer and occupancy registers; reset and flush discard any same-cycle push/pop.
    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(pop_cnt_s);
            tail_r  <= tail_r + PTR_W'(push_cnt_s);
            count_r <= count_r + (PTR_W+1)'(push_cnt_s) - (PTR_W+1)'(pop_cnt_s);
        end
    end

    inst_queue_ctrl_chk #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_chk (
        .clk      (Clk),
        .rst      (Rst),
        .flush    (Flush),
        .stall    (Stall),
        .in_ready (In_Ready),
        .count    (count_r),
        .out_port (Out_Port)
    );

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Bench for inst_queue_ctrl: directed vector table for the corner cases, then
// randomized traffic checked against a queue-based reference model.
module tb_inst_queue_ctrl;
    import inst_queue_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           stall;
    logic [97:0]    in_port;
    logic           in_ready;
    logic [97:0]    out_port;
    logic [PTR_W:0] count;
    if_id_port_t    out_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inst_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Flush    (flush),
        .Stall    (stall),
        .In_Port  (in_port),
        .In_Ready (in_ready),
        .Out_Port (out_port),
        .Count    (count)
    );

    assign out_s = if_id_port_t'(out_port);

    typedef struct packed {
        logic        r, f, s, e1, e2;
        logic [31:0] i1, i2, pc;
        logic [31:0] e_cnt;
        logic        e_rdy, e_en1, e_en2;
        logic [31:0] e_pc;
    } vec_t;

    vec_t      vecs[$];
    iq_entry_t mq[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t v(input logic r, f, s, e1, e2, input logic [31:0] pc,
                               input int c, input logic rdy, x1, x2, input logic [31:0] epc);
        vec_t t;
        t = '{r: r, f: f, s: s, e1: e1, e2: e2, i1: ins(pc), i2: ins(pc + 32'd4), pc: pc,
              e_cnt: 32'(c), e_rdy: rdy, e_en1: x1, e_en2: x2, e_pc: epc};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, f, s, e1, e2, input logic [31:0] i1, i2, pc);
        rst     = r;
        flush   = f;
        stall   = s;
        in_port = {i1, e1, i2, e2, pc};
    endtask

    task automatic compare(input string tag, input logic [31:0] cnt, input logic rdy,
                           input logic x1, input logic x2, input logic [31:0] pc,
                           input logic [31:0] i1, input logic [31:0] i2);
        check({tag, " count"}, 32'(count), cnt);
        check({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        check({tag, " inst1_en"}, 32'(out_s.inst1_en), 32'(x1));
        check({tag, " inst2_en"}, 32'(out_s.inst2_en), 32'(x2));
        if (x1) begin
            check({tag, " pc"}, out_s.pc, pc);
            check({tag, " inst1"}, out_s.inst1, i1);
        end
        if (x2) check({tag, " inst2"}, out_s.inst2, i2);
    endtask

    initial begin
        logic        r, f, s, e1, e2, rdy, m1, m2;
        logic [31:0] pc_v, i1, i2, exp_i1, exp_i2, exp_pc;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        //            r  f  s  e1 e2 pc           cnt rdy x1 x2 exp_pc
        vecs.push_back(v(1, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00400000, 2, 1, 1, 1, 32'h00400000));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h1000,  2, 1, 1, 1, 32'h1000));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h1008,  4, 1, 1, 1, 32'h1000));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h1010,  6, 1, 1, 1, 32'h1000));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h1018,  8, 0, 1, 1, 32'h1000));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h2000,  8, 0, 1, 1, 32'h1000));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     6, 1, 1, 1, 32'h1008));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     4, 1, 1, 1, 32'h1010));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     2, 1, 1, 1, 32'h1018));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 1, 0, 32'h100,   1, 1, 1, 0, 32'h100));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h200,   3, 1, 1, 0, 32'h100));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     2, 1, 1, 1, 32'h200));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h300,   2, 1, 1, 1, 32'h300));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h308,   4, 1, 1, 1, 32'h300));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h310,   5, 1, 1, 1, 32'h300));
        vecs.push_back(v(0, 1, 0, 1, 1, 32'h400,   0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h400,   2, 1, 1, 1, 32'h400));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h408,   4, 1, 1, 1, 32'h400));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h410,   6, 1, 1, 1, 32'h400));
        vecs.push_back(v(1, 0, 1, 1, 1, 32'h500,   0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h600,   1, 1, 1, 0, 32'h604));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 1, 1, 0, 32'h700,   1, 1, 1, 0, 32'h700));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h708,   3, 1, 1, 0, 32'h700));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h710,   5, 1, 1, 0, 32'h700));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h718,   7, 0, 1, 0, 32'h700));
        vecs.push_back(v(0, 0, 1, 1, 1, 32'h720,   7, 0, 1, 0, 32'h700));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     6, 1, 1, 1, 32'h708));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     4, 1, 1, 1, 32'h710));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     2, 1, 1, 1, 32'h718));
        vecs.push_back(v(0, 0, 0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0));

        // The first real push uses fixed instruction words rather than the PC-derived ones.
        vecs[1].i1 = 32'h2402_0001;
        vecs[1].i2 = 32'h2403_0002;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].r, vecs[k].f, vecs[k].s, vecs[k].e1, vecs[k].e2,
                  vecs[k].i1, vecs[k].i2, vecs[k].pc);
            @(posedge clk);
            #1;
            exp_i1 = (k == 1) ? 32'h2402_0001 : ins(vecs[k].e_pc);
            exp_i2 = (k == 1) ? 32'h2403_0002 : ins(vecs[k].e_pc + 32'd4);
            compare($sformatf("vec%0d", k), vecs[k].e_cnt, vecs[k].e_rdy, vecs[k].e_en1,
                    vecs[k].e_en2, vecs[k].e_pc, exp_i1, exp_i2);
        end

        // Randomized traffic; the queue is empty here, matching an empty model.
        pc_v = 32'h0000_8000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 9) < 4);
            e1 = $urandom_range(0, 3) != 0;
            e2 = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 5) == 0) pc_v = $urandom & 32'hFFFF_FFFC;
            i1 = $urandom;
            i2 = $urandom;
            drive(r, f, s, e1, e2, i1, i2, pc_v);

            rdy = (DEPTH - mq.size()) >= 2;
            m1  = mq.size() >= 1;
            m2  = (mq.size() >= 2) && (mq[1].pc == mq[0].pc + 32'd4);
            if (r || f) begin
                mq.delete();
            end else begin
                if (!s && m1) void'(mq.pop_front());
                if (!s && m2) void'(mq.pop_front());
                if (rdy && e1) mq.push_back('{inst: i1, pc: pc_v});
                if (rdy && e2) mq.push_back('{inst: i2, pc: pc_v + 32'd4});
            end
            if (rdy && (e1 || e2) && !r && !f) pc_v = pc_v + 32'd8;

            @(posedge clk);
            #1;
            m1     = mq.size() >= 1;
            m2     = (mq.size() >= 2) && (mq[1].pc == mq[0].pc + 32'd4);
            exp_pc = m1 ? mq[0].pc : 32'h0;
            exp_i1 = m1 ? mq[0].inst : 32'h0;
            exp_i2 = m2 ? mq[1].inst : 32'h0;
            compare($sformatf("rnd%0d", cyc), 32'(mq.size()), (DEPTH - mq.size()) >= 2,
                    m1, m2, exp_pc, exp_i1, exp_i2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
